// File: rtl/multicycle_control.sv
// Control FSM for a shared-memory multi-cycle MIPS datapath, with memory wait states and a sticky trap.
// Define MULTICYCLE_CTRL_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             mem_ready,
    output logic             PC_w,
    output logic             PC_w_cond,
    output logic             IorD,
    output logic             Mem_r,
    output logic             Mem_w,
    output logic             IR_w,
    output logic             Mem_to_reg,
    output logic             Reg_dst,
    output logic             Reg_w,
    output logic             ALU_srcA,
    output logic [1:0]       ALU_srcB,
    output logic [1:0]       ALU_op,
    output logic [1:0]       PC_src,
    output logic             instr_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state_o
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instr_cnt
`endif
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [1:0]        cause_q, cause_d;
    logic              timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // The limit is reached on the MEM_TIMEOUT-th consecutive cycle with mem_ready low.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && ((int'(wait_q) + 1) == MEM_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        wait_d     = '0;
        PC_w       = 1'b0;
        PC_w_cond  = 1'b0;
        IorD       = 1'b0;
        Mem_r      = 1'b0;
        Mem_w      = 1'b0;
        IR_w       = 1'b0;
        Mem_to_reg = 1'b0;
        Reg_dst    = 1'b0;
        Reg_w      = 1'b0;
        ALU_srcA   = 1'b0;
        ALU_srcB   = 2'b00;
        ALU_op     = 2'b00;
        PC_src     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                Mem_r    = 1'b1;
                ALU_srcB = 2'b01;
                IR_w     = mem_ready;
                PC_w     = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                ALU_srcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW, OP_ADDI: state_d = S_MEM_ADDR;
                    OP_R:                  state_d = S_EXEC;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALU_srcA = 1'b1;
                ALU_srcB = 2'b10;
                case (Opcode)
                    OP_LW:   state_d = S_MEM_RD;
                    OP_SW:   state_d = S_MEM_WR;
                    OP_ADDI: state_d = S_ADDI_WB;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_MEM_RD: begin
                Mem_r = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_MEM_WB: begin
                Mem_to_reg = 1'b1;
                Reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                Mem_w = 1'b1;
                IorD  = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                ALU_srcA = 1'b1;
                ALU_op   = 2'b10;
                state_d  = S_R_WB;
            end
            S_R_WB: begin
                Reg_dst    = 1'b1;
                Reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_WB: begin
                Reg_w      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALU_srcA   = 1'b1;
                ALU_op     = 2'b01;
                PC_w_cond  = 1'b1;
                PC_src     = 2'b01;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PC_w       = 1'b1;
                PC_src     = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_o    = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) cycle_q <= cycle_q + 1'b1;
            if (instr_done) instr_q <= instr_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule
